// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared sizing helpers for the FIFO write-side arbiters.
package fifo_wr_arbiter_pkg;

    // Ceiling log2. Returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Tag width for n requesters, never narrower than one bit.
    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb.sv
// Combinational round-robin arbiter.
// The request vector is rotated so that index ptr sits at bit 0. A fixed
// priority search then finds the lowest set bit, and the result is rotated
// back into absolute index space.
module rr_arb
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NR = 4,
    localparam int IW = tag_w(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NR-1:0] gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [NR-1:0] rot;
    int            idx;

    // Rotate by ptr, pick the lowest set bit, then map back modulo NR.
    always_comb begin
        rot     = NR'({req, req} >> ptr);
        any     = |rot;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (rot[k]) idx = int'(ptr) + k;
        end
        // The wrap is explicit so that non-power-of-two NR works.
        if (idx >= NR) idx = idx - NR;
        for (int i = 0; i < NR; i++) begin
            gnt[i] = any && (idx == i);
        end
        if (any) gnt_idx = IW'(idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NR producers.
// Accepted words go into a single staging register, tagged with the index
// of the requester they came from. The stage is refilled in the same cycle
// it drains, which sustains one word per cycle.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NR = 4,
    parameter  int DW = 32,
    localparam int IW = tag_w(NR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             en,
    input  logic [NR-1:0]    req_valid,
    input  logic [NR*DW-1:0] req_data,
    output logic [NR-1:0]    req_ready,
    output logic [DW+IW-1:0] fifo_in,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic             busy
);

    logic             stg_vld;
    logic [DW+IW-1:0] stg_data;
    logic [IW-1:0]    rr_ptr;

    logic [NR-1:0]    gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             stage_free;
    logic             transfer;
    logic [DW-1:0]    sel_data;
    logic [IW-1:0]    ptr_next;

    rr_arb #(.NR(NR)) u_rr_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign fifo_wr_en = clk_en & en & stg_vld & ~fifo_full;
    assign stage_free = ~stg_vld | fifo_wr_en;
    assign req_ready  = (clk_en & en & stage_free) ? gnt : '0;
    assign transfer   = clk_en & en & stage_free & gnt_any;
    assign fifo_in    = stg_data;
    assign busy       = stg_vld | (|req_valid);
    assign ptr_next   = (int'(gnt_idx) == NR - 1) ? '0 : gnt_idx + IW'(1);

    // Select the data word of the granted requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NR; i++) begin
            if (gnt[i]) sel_data = req_data[i*DW +: DW];
        end
    end

    // Stage register and round-robin pointer. Reset wins over clk_en and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld  <= 1'b0;
            stg_data <= '0;
            rr_ptr   <= '0;
        end else if (clk_en) begin
            if (!en) begin
                // Flush: the staged word is dropped, not written.
                stg_vld <= 1'b0;
                rr_ptr  <= '0;
            end else if (transfer) begin
                stg_data <= {gnt_idx, sel_data};
                stg_vld  <= 1'b1;
                rr_ptr   <= ptr_next;
            end else if (fifo_wr_en) begin
                stg_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the arbiter.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst, clk_en, en, fifo_full;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [33:0]  fifo_in;
    logic         fifo_wr_en, busy;

    logic [2:0]   req_valid3;
    logic [95:0]  req_data3;
    logic [2:0]   req_ready3;
    logic [33:0]  fifo_in3;
    logic         fifo_wr_en3, busy3;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NR(4), .DW(32)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_in(fifo_in), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .busy(busy)
    );

    fifo_wr_arbiter #(.NR(3), .DW(32)) dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .en(en),
        .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
        .fifo_in(fifo_in3), .fifo_wr_en(fifo_wr_en3), .fifo_full(fifo_full),
        .busy(busy3)
    );

    // Reference model state (NR=4 instance).
    bit          m_vld;
    logic [33:0] m_word;
    int          m_ptr;
    bit          e_wr;
    int          e_g;
    logic [3:0]  e_ready;

    int passed = 0;
    int total  = 0;
    int acc_q[$];
    int exp_tags[6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int n, idx;
        n = 0; idx = -1;
        for (int i = 0; i < 4; i++) if (v[i]) begin n++; idx = i; end
        return (n > 1) ? -2 : idx;
    endfunction

    // Compute expected combinational outputs from the model and compare.
    task automatic settle_check();
        #2;
        e_wr = clk_en && en && m_vld && !fifo_full;
        e_g  = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (e_g < 0 && req_valid[i]) e_g = i;
        end
        e_ready = (clk_en && en && (!m_vld || e_wr) && e_g >= 0) ? (4'b0001 << e_g) : 4'b0000;
        chk("fifo_wr_en", {63'b0, fifo_wr_en}, {63'b0, e_wr});
        chk("req_ready", {60'b0, req_ready}, {60'b0, e_ready});
        chk("fifo_in", {30'b0, fifo_in}, {30'b0, m_word});
        chk("busy", {63'b0, busy}, {63'b0, (m_vld || (|req_valid))});
        if ((req_ready & req_valid) != 4'b0000) acc_q.push_back(oh_idx(req_ready));
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            m_vld = 0; m_word = '0; m_ptr = 0;
        end else if (clk_en) begin
            if (!en) begin
                m_vld = 0; m_ptr = 0;
            end else if (e_ready != 4'b0000) begin
                m_word = {e_g[1:0], req_data[e_g*32 +: 32]};
                m_vld  = 1;
                m_ptr  = (e_g + 1) % 4;
            end else if (e_wr) begin
                m_vld = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b1; en = 1'b1; fifo_full = 1'b0;
        req_valid = '0; req_valid3 = '0;
        @(posedge clk);
        #1;
        m_vld = 0; m_word = '0; m_ptr = 0;
        rst = 1'b0;
    endtask

    initial begin
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

        // Reset state.
        do_reset();
        settle_check();
        chk("reset wr_en", {63'b0, fifo_wr_en}, 64'd0);
        chk("reset fifo_in", {30'b0, fifo_in}, 64'd0);
        chk("reset ready", {60'b0, req_ready}, 64'd0);
        tick();

        // All four requesters valid: tags rotate 0,1,2,3,0,1.
        do_reset();
        acc_q.delete();
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            settle_check();
            if (c >= 1) begin
                chk("stream wr_en", {63'b0, fifo_wr_en}, 64'd1);
                chk("stream tag", {62'b0, fifo_in[33:32]}, 64'(exp_tags[c-1]));
            end
            tick();
        end
        chk("stream count", 64'(acc_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < acc_q.size(); i++) chk("stream order", 64'(acc_q[i]), 64'(exp_tags[i]));

        // Single requester 2.
        do_reset();
        req_valid = 4'b0100;
        req_data[95:64] = 32'hA5A5_A5A5;
        settle_check();
        tick();
        req_valid = 4'b0000;
        settle_check();
        chk("single fifo_in", {30'b0, fifo_in}, {30'b0, 2'd2, 32'hA5A5_A5A5});
        chk("single wr_en", {63'b0, fifo_wr_en}, 64'd1);
        tick();
        req_valid = 4'hF;
        settle_check();
        chk("single next grant", {60'b0, req_ready}, 64'b1000);
        tick();

        // Backpressure with tag 1 staged.
        do_reset();
        req_valid = 4'b0010;
        settle_check();
        tick();
        req_valid = 4'hF;
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle_check();
            chk("bp wr_en", {63'b0, fifo_wr_en}, 64'd0);
            chk("bp ready", {60'b0, req_ready}, 64'd0);
            tick();
        end
        fifo_full = 1'b0;
        settle_check();
        chk("bp release wr", {63'b0, fifo_wr_en}, 64'd1);
        chk("bp release tag", {62'b0, fifo_in[33:32]}, 64'd1);
        chk("bp resume grant", {60'b0, req_ready}, 64'b0100);
        tick();

        // clk_en toggling with all valid.
        do_reset();
        acc_q.delete();
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            clk_en = (c % 2 == 0);
            settle_check();
            if (!clk_en) begin
                chk("ce0 ready", {60'b0, req_ready}, 64'd0);
                chk("ce0 wr_en", {63'b0, fifo_wr_en}, 64'd0);
            end
            tick();
        end
        clk_en = 1'b1;
        chk("ce count", 64'(acc_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("ce order", 64'(acc_q[i]), 64'(exp_tags[i]));

        // en low flushes a staged word.
        do_reset();
        req_valid = 4'b0100;
        settle_check();
        tick();
        req_valid = 4'b1010;
        en = 1'b0;
        settle_check();
        chk("en0 wr_en", {63'b0, fifo_wr_en}, 64'd0);
        chk("en0 ready", {60'b0, req_ready}, 64'd0);
        tick();
        en = 1'b1;
        settle_check();
        chk("en1 wr_en", {63'b0, fifo_wr_en}, 64'd0);
        chk("en1 grant", {60'b0, req_ready}, 64'b0010);
        tick();

        // Reset with the stage valid.
        do_reset();
        req_valid = 4'b0001;
        settle_check();
        tick();
        req_valid = 4'b0000;
        rst = 1'b1;
        settle_check();
        tick();
        rst = 1'b0;
        settle_check();
        chk("rst mid wr_en", {63'b0, fifo_wr_en}, 64'd0);
        chk("rst mid fifo_in", {30'b0, fifo_in}, 64'd0);
        tick();

        // NR=3 instance, all valid.
        do_reset();
        req_valid3 = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle_check();
            chk("nr3 grant", {61'b0, req_ready3}, 64'(3'b001 << (c % 3)));
            if (c >= 1) begin
                chk("nr3 tag", {62'b0, fifo_in3[33:32]}, 64'((c - 1) % 3));
                chk("nr3 data", {32'b0, fifo_in3[31:0]}, {32'b0, 32'h3333_0000 + 32'((c - 1) % 3)});
                chk("nr3 wr_en", {63'b0, fifo_wr_en3}, 64'd1);
            end
            tick();
        end
        req_valid3 = 3'b000;

        // Random traffic honouring the requester contract.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] took;
            rst       = ($urandom % 50) == 0;
            clk_en    = ($urandom % 8) != 0;
            en        = ($urandom % 16) != 0;
            fifo_full = ($urandom % 4) == 0;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom % 2) == 1) begin
                    req_valid[i] = 1'b1;
                    req_data[i*32 +: 32] = $urandom;
                end
            end
            settle_check();
            took = rst ? 4'b0000 : (e_ready & req_valid);
            tick();
            req_valid = req_valid & ~took;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one sync_fifo write port between NR result producers, e.g. the Mandelbrot iteration engines.
- Round-robin arbitration with valid/ready handshakes per requester.
- One registered staging word, tagged with the requester index, drives the FIFO write side.
- Sits between the engine array and the result FIFO; the consumer uses the tag to route or reorder results.

Parameters:
- NR, 4, number of requesters (≥2)
- DW, 32, requester data width
- IW, clog2(NR), tag width (derived localparam, not overridable)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- clk_en  input  1  clock enable; all state holds when low
- en  input  1  block enable; low flushes state synchronously
- req_valid  input  NR  requester i has a word
- req_data  input  NR*DW  word i at bits [i*DW +: DW]
- req_ready  output  NR  one-hot accept to requester i
- fifo_in  output  DW+IW  {tag, data} to FIFO write data
- fifo_wr_en  output  1  FIFO write strobe
- fifo_full  input  1  FIFO full flag
- busy  output  1  stage occupied or any req_valid

Behaviour:
- Reset, on rising clk with rst=1:
  - stg_vld=0, stg_data=0, rr_ptr=0.
  - Hence fifo_wr_en=0, fifo_in=0, req_ready=0.
- Reset has priority over clk_en and en.
- fifo_wr_en = clk_en & en & stg_vld & !fifo_full (combinational). fifo_in = stg_data.
- stage_free = !stg_vld | fifo_wr_en.
  - The stage accepts a new word in the same cycle its old word is written.
  - Sustained throughput: 1 word/cycle.
- Grant selection:
  - Grant goes to the first index with req_valid=1, searching from rr_ptr upward and wrapping modulo NR.
  - No valid requester gives grant=0.
- req_ready[i] = clk_en & en & stage_free & grant[i]. At most one bit is set.
  - req_ready may depend combinationally on req_valid and fifo_full.
- Transfer occurs when req_valid[i] & req_ready[i]. On transfer, with clk_en=1 and en=1:
  - stg_data <= {i[IW-1:0], req_data[i]}
  - stg_vld <= 1
  - rr_ptr <= (i+1) mod NR
  - For non-power-of-two NR, the wrap is explicit.
- If fifo_wr_en=1 with no transfer, stg_vld <= 0. rr_ptr is unchanged on cycles without a transfer.
- Latency: a word accepted at edge N appears with fifo_wr_en high in cycle N+1 if fifo_full=0.
- FIFO full:
  - The stage holds its word and no grants are issued.
  - The word is written in the first cycle fifo_full=0.
- clk_en=0:
  - All registers hold.
  - req_ready=0 and fifo_wr_en=0.
- en=0:
  - On the next enabled edge, stg_vld<=0 and rr_ptr<=0; any staged word is discarded.
  - req_ready=0 and fifo_wr_en=0 while en=0.
- Requester contract:
  - req_data[i] is held stable and req_valid[i] stays high until accepted.
  - The arbiter does not check this contract.
- Fairness: with all NR requesters continuously valid, each is granted exactly once per NR transfers.
- Reset mid-operation: the staged word is lost. Requesters keep their valid and retry after reset.

Decomposition:
- Shared header/package holds:
  - the clog2 function (same definition as the FIFO's)
  - a TAG_W helper
- Sub-module rr_arb: combinational rotate/priority/unrotate.
  - Inputs: req[NR], ptr[IW].
  - Outputs: gnt[NR] one-hot, gnt_idx[IW], any.
  - It is reused by later arbiters.
- Top level holds the stage register, rr_ptr and the handshake logic.

Test Plan:
- Reset, NR=4: req_valid=4'b1111, FIFO not full.
  - Accepted tags follow 0,1,2,3,0,1.
  - fifo_wr_en stays high every cycle from the second cycle onward.
- Single requester: req_valid=4'b0100, data=0xA5A5A5A5.
  - fifo_in=0x2_A5A5A5A5 (tag 2) one cycle after acceptance.
  - rr_ptr becomes 3.
- Backpressure: fifo_full=1 for 5 cycles while the stage holds tag 1.
  - fifo_wr_en=0 and req_ready=0 throughout.
  - Word written in the first cycle after full drops.
  - Next grant resumes from index 2.
- clk_en toggling 1,0,1,0 with all valid:
  - No transfers or writes on clk_en=0 cycles.
  - Grant order is identical to the clk_en=1 run.
- en=0 mid-stream with the stage valid:
  - Staged word never written; rr_ptr=0.
  - After en=1, first grant goes to the lowest valid index.
- NR=3 sweep with all valid: tags 0,1,2,0 and no out-of-range tag.
- Synchronous rst asserted with the stage valid: stg_vld=0 and fifo_wr_en=0 on the next edge.
